// File: rtl/rv32m_multiplier.sv
// Fully pipelined RV32M multiply unit, STAGES cycles from issue to writeback.
// Define MULT_HIGH_EN for MULH/MULHSU/MULHU; without it only MUL (low word) is built.
module rv32m_multiplier #(
  parameter int unsigned STAGES = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_on,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  input  logic        sigA,
  input  logic        sigB,
  input  logic        upper,
  output logic        done,
  output logic [31:0] writeback_value_o
);

  // One operand stage, PpDepth partial-product stages, one output stage.
  localparam int unsigned PpDepth = STAGES - 1;

`ifdef MULT_HIGH_EN
  typedef struct packed {
    logic [31:0] ll;
    logic [31:0] lh;
    logic [31:0] hl;
    logic [31:0] hh;
    logic [31:0] corr;
    logic        upper;
  } pp_t;
`else
  typedef struct packed {
    logic [31:0] ll;
    logic [15:0] lh;
    logic [15:0] hl;
  } pp_t;

  logic unused_ctrl;
  assign unused_ctrl = ^{sigA, sigB, upper};
`endif

  logic        v1_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
`ifdef MULT_HIGH_EN
  logic        sa_q;
  logic        sb_q;
  logic        up_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= mult_on;
    end
  end

  always_ff @(posedge clk) begin
    if (mult_on) begin
      a_q  <= A_i;
      b_q  <= B_i;
`ifdef MULT_HIGH_EN
      sa_q <= sigA;
      sb_q <= sigB;
      up_q <= upper;
`endif
    end
  end

  pp_t pp_d;

  always_comb begin
    pp_d    = '0;
    pp_d.ll = {16'b0, a_q[15:0]} * {16'b0, b_q[15:0]};
`ifdef MULT_HIGH_EN
    pp_d.lh    = {16'b0, a_q[15:0]} * {16'b0, b_q[31:16]};
    pp_d.hl    = {16'b0, a_q[31:16]} * {16'b0, b_q[15:0]};
    pp_d.hh    = {16'b0, a_q[31:16]} * {16'b0, b_q[31:16]};
    // signed x = unsigned x - 2^32*msb, so each signed-negative operand removes the other
    // operand from the high word of the unsigned product.
    pp_d.corr  = ((sa_q && a_q[31]) ? b_q : 32'd0) + ((sb_q && b_q[31]) ? a_q : 32'd0);
    pp_d.upper = up_q;
`else
    pp_d.lh = a_q[15:0] * b_q[31:16];
    pp_d.hl = a_q[31:16] * b_q[15:0];
`endif
  end

  logic [PpDepth-1:0] pv_q;
  pp_t                pp_q [PpDepth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= v1_q;
      for (int unsigned i = 1; i < PpDepth; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pp_q[0] <= pp_d;
    for (int unsigned i = 1; i < PpDepth; i++) begin
      pp_q[i] <= pp_q[i-1];
    end
  end

  pp_t         pp_last;
  logic [31:0] res_d;

  assign pp_last = pp_q[PpDepth-1];

`ifdef MULT_HIGH_EN
  logic [63:0] prod;

  always_comb begin
    prod  = {pp_last.hh, pp_last.ll} + {16'b0, pp_last.lh, 16'b0}
          + {16'b0, pp_last.hl, 16'b0} - {pp_last.corr, 32'b0};
    res_d = pp_last.upper ? prod[63:32] : prod[31:0];
  end
`else
  always_comb begin
    res_d = pp_last.ll + {pp_last.lh, 16'b0} + {pp_last.hl, 16'b0};
  end
`endif

  logic        done_q;
  logic [31:0] wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      wb_q   <= '0;
    end else begin
      done_q <= pv_q[PpDepth-1];
      if (pv_q[PpDepth-1]) begin
        wb_q <= res_d;
      end
    end
  end

  assign done              = done_q;
  assign writeback_value_o = wb_q;

endmodule

// File: tb/tb_rv32m_multiplier.sv
// Self-checking bench for rv32m_multiplier: random and directed ops against an arithmetic model.
// Builds with or without MULT_HIGH_EN, matching the DUT build.
module tb_rv32m_multiplier;

  localparam int STAGES = 7;
`ifdef MULT_HIGH_EN
  localparam bit HighEn = 1'b1;
`else
  localparam bit HighEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_on = 1'b0;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic        sigA = 1'b0;
  logic        sigB = 1'b0;
  logic        upper = 1'b0;
  logic        done;
  logic [31:0] writeback_value_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          cyc;
    logic [31:0] res;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_val = '0;

  rv32m_multiplier #(.STAGES(STAGES)) dut (
    .clk              (clk),
    .rst              (rst),
    .mult_on          (mult_on),
    .A_i              (A_i),
    .B_i              (B_i),
    .sigA             (sigA),
    .sigB             (sigB),
    .upper            (upper),
    .done             (done),
    .writeback_value_o(writeback_value_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb, input logic up);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (up && HighEn) ? p[63:32] : p[31:0];
  endfunction

  // Drive one cycle; after the edge, exp_done/exp_val say what the DUT should show.
  task automatic drive(input logic on, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic up);
    exp_t e;
    @(negedge clk);
    mult_on = on;
    A_i     = a;
    B_i     = b;
    sigA    = sa;
    sigB    = sb;
    upper   = up;
    @(posedge clk);
    cyc++;
    if (on) begin
      e.cyc = cyc;
      e.res = model(a, b, sa, sb, up);
      exp_q.push_back(e);
    end
    #1;
    exp_done = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc + STAGES == cyc) begin
      exp_done = 1'b1;
      exp_val  = exp_q[0].res;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || writeback_value_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: done=%b val=%08h, want done=0 val=00000000",
               done, writeback_value_o);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_val  = '0;
    exp_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (done !== 1'b0 || writeback_value_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL idle_after_reset: done=%b val=%08h, want 0/00000000",
                 done, writeback_value_o);
      end
    end
  endtask

  task automatic test_spec_mul();
    logic [31:0] a_v  [3] = '{32'h9, 32'h00A03009, 32'h3209};
    logic [31:0] b_v  [3] = '{32'h7, 32'h107, 32'h1A};
    logic [31:0] want [3] = '{32'h0000003F, 32'hA491593F, 32'h000514EA};
    int n = 0;
    drive(1'b1, 32'h80000001, 32'h80010002, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= STAGES; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (k == STAGES) begin
        if (done !== 1'b1 || writeback_value_o !== 32'h80010002) begin
          tests_failed++;
          $display("FAIL mul_latency: done=%b val=%08h, want done=1 val=80010002",
                   done, writeback_value_o);
        end
      end else if (done !== 1'b0) begin
        tests_failed++;
        $display("FAIL mul_early_done: k=%0d done=%b, want 0", k, done);
      end
    end
    for (int k = 0; k < 3 + STAGES + 1; k++) begin
      if (k < 3) drive(1'b1, a_v[k], b_v[k], 1'($urandom), 1'($urandom), 1'b0);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (done !== exp_done || writeback_value_o !== exp_val) begin
        tests_failed++;
        $display("FAIL mul_b2b: cyc=%0d done=%b val=%08h, want done=%b val=%08h",
                 cyc, done, writeback_value_o, exp_done, exp_val);
      end
      if (done === 1'b1) begin
        if (n < 3) begin
          tests_run++;
          if (writeback_value_o !== want[n]) begin
            tests_failed++;
            $display("FAIL mul_vector%0d: val=%08h, want %08h", n, writeback_value_o, want[n]);
          end
        end
        n++;
      end
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL mul_b2b_count: got %0d dones, want 3", n);
    end
  endtask

`ifdef MULT_HIGH_EN
  task automatic test_upper();
    logic [31:0] a_v  [3] = '{32'h80000001, 32'h80000001, 32'hFFFFFFFF};
    logic [31:0] b_v  [3] = '{32'h80010002, 32'h80010002, 32'h00000002};
    logic        sa_v [3] = '{1'b1, 1'b0, 1'b1};
    logic        sb_v [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] want [3] = '{32'h3FFF7FFE, 32'h40008001, 32'hFFFFFFFF};
    int n = 0;
    for (int k = 0; k < 3 + STAGES + 1; k++) begin
      if (k < 3) drive(1'b1, a_v[k], b_v[k], sa_v[k], sb_v[k], 1'b1);
      else       drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      tests_run++;
      if (done !== exp_done || writeback_value_o !== exp_val) begin
        tests_failed++;
        $display("FAIL upper_b2b: cyc=%0d done=%b val=%08h, want done=%b val=%08h",
                 cyc, done, writeback_value_o, exp_done, exp_val);
      end
      if (done === 1'b1) begin
        if (n < 3) begin
          tests_run++;
          if (writeback_value_o !== want[n]) begin
            tests_failed++;
            $display("FAIL upper_vector%0d: val=%08h, want %08h", n, writeback_value_o, want[n]);
          end
        end
        n++;
      end
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL upper_count: got %0d dones, want 3", n);
    end
  endtask
`else
  task automatic test_no_high();
    drive(1'b1, 32'h80000001, 32'h80010002, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= STAGES; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    tests_run++;
    if (done !== 1'b1 || writeback_value_o !== 32'h80010002) begin
      tests_failed++;
      $display("FAIL no_high_mul: done=%b val=%08h, want done=1 val=80010002",
               done, writeback_value_o);
    end
  endtask
`endif

  task automatic test_alternate();
    for (int k = 0; k < 24 + STAGES + 1; k++) begin
      if (k < 24 && (k % 2) == 0) begin
        drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      tests_run++;
      if (done !== exp_done || writeback_value_o !== exp_val) begin
        tests_failed++;
        $display("FAIL alternate: cyc=%0d done=%b val=%08h, want done=%b val=%08h",
                 cyc, done, writeback_value_o, exp_done, exp_val);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h80000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h0;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400 + STAGES + 1; k++) begin
      if (k < 400) begin
        drive($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
              1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      tests_run++;
      if (done !== exp_done || writeback_value_o !== exp_val) begin
        tests_failed++;
        $display("FAIL random: cyc=%0d done=%b val=%08h, want done=%b val=%08h",
                 cyc, done, writeback_value_o, exp_done, exp_val);
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom | 32'h1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (done !== 1'b0 || writeback_value_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_async: done=%b val=%08h, want done=0 val=00000000",
               done, writeback_value_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_val  = '0;
    exp_done = 1'b0;
    for (int k = 0; k < STAGES + 2; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (done !== 1'b0 || writeback_value_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_drop: cyc=%0d done=%b val=%08h, want done=0 val=00000000",
                 cyc, done, writeback_value_o);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_spec_mul();
`ifdef MULT_HIGH_EN
    test_upper();
`else
    test_no_high();
`endif
    test_alternate();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
